// File: rtl/i2s_rx_slave.sv
// I2S (Philips format) slave receiver: synchronises pad inputs, deserialises
// channel-tagged words on SCK rising edges and buffers them in a FWFT FIFO.
module i2s_rx_slave #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          sck_i,
    input  logic                          ws_i,
    input  logic                          sd_i,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_chan,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    // Synchroniser and edge-detect state
    logic sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_prev_q, sck_prev_d;
    logic ws_s1_q, ws_s1_d, ws_s2_q, ws_s2_d;
    logic sd_s1_q, sd_s1_d, sd_s2_q, sd_s2_d;

    // Deserialiser state
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  synced_q, synced_d;
    logic                  ws_prev_q, ws_prev_d;

    // FIFO state
    logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  overflow_q, overflow_d;

    logic                  sck_rise, boundary, push, pop, full, wr_en, ovf_set;
    logic [DATA_WIDTH-1:0] bit_sel, shreg_cap;
    logic [CW-1:0]         cnt_inc;
    logic [DATA_WIDTH:0]   head;

    always_comb begin
        sck_s1_d   = sck_i;
        sck_s2_d   = sck_s1_q;
        sck_prev_d = sck_s2_q;
        ws_s1_d    = ws_i;
        ws_s2_d    = ws_s1_q;
        sd_s1_d    = sd_i;
        sd_s2_d    = sd_s1_q;
    end

    assign sck_rise = sck_s2_q & ~sck_prev_q;
    assign boundary = ws_s2_q != ws_prev_q;

    // One-hot select of the shreg bit addressed by bit_cnt; all-zero once the slot exceeds DATA_WIDTH.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (bit_cnt_q == CW'(DATA_WIDTH - 1 - gi));
        end
    endgenerate

    assign shreg_cap = shreg_q | (bit_sel & {DATA_WIDTH{sd_s2_q}});
    assign cnt_inc   = (bit_cnt_q < CW'(DATA_WIDTH)) ? bit_cnt_q + CW'(1) : bit_cnt_q;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        synced_d  = synced_q;
        ws_prev_d = ws_prev_q;
        push      = 1'b0;
        if (!enable) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
            synced_d  = 1'b0;
            ws_prev_d = ws_s2_q;
        end else if (sck_rise) begin
            if (boundary) begin
                // The boundary bit is the outgoing word's LSB slot, already folded into shreg_cap.
                push      = synced_q;
                synced_d  = 1'b1;
                shreg_d   = '0;
                bit_cnt_d = '0;
                ws_prev_d = ws_s2_q;
            end else begin
                shreg_d   = shreg_cap;
                bit_cnt_d = cnt_inc;
            end
        end
    end

    assign m_valid = level_q != '0;
    assign full    = level_q == LW'(FIFO_DEPTH);
    assign pop     = m_valid && m_ready;
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d    = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        overflow_d = overflow_q;
        if (ovf_clr) overflow_d = 1'b0;
        if (ovf_set) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_prev_q <= 1'b0;
            ws_s1_q    <= 1'b0;
            ws_s2_q    <= 1'b0;
            sd_s1_q    <= 1'b0;
            sd_s2_q    <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            synced_q   <= 1'b0;
            ws_prev_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sck_s1_q   <= sck_s1_d;
            sck_s2_q   <= sck_s2_d;
            sck_prev_q <= sck_prev_d;
            ws_s1_q    <= ws_s1_d;
            ws_s2_q    <= ws_s2_d;
            sd_s1_q    <= sd_s1_d;
            sd_s2_q    <= sd_s2_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            synced_q   <= synced_d;
            ws_prev_q  <= ws_prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: level_q gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {ws_prev_q, shreg_cap};
    end

    assign head       = mem_q[rd_ptr_q];
    assign m_data     = m_valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_chan     = m_valid ? head[DATA_WIDTH] : 1'b0;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_i2s_rx_slave.sv
// Directed bench for i2s_rx_slave: an I2S master model at SCK = clk/8 and a
// pop monitor that records every accepted {chan, data} word.
module tb_i2s_rx_slave;

    logic        clk = 1'b0;
    logic        rst, enable, sck_i, ws_i, sd_i, m_ready, ovf_clr;
    logic        m_valid, m_chan, overflow;
    logic [15:0] m_data;
    logic [2:0]  fifo_level;

    int          n_chk = 0;
    int          n_bad = 0;
    logic        pend;
    logic [16:0] q [$];
    logic [15:0] w [6];

    i2s_rx_slave #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
        .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            q.push_back({m_chan, m_data});
            $display("pop chan=%0d data=%h level=%0d", m_chan, m_data, fifo_level);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCK period: data/WS change with SCK low, slave samples on the rise.
    // With pop=1, m_ready is high for exactly the cycle in which this rise is pushed.
    task automatic send_bit(input logic ws, input logic sd, input bit pop);
        sck_i = 1'b0;
        ws_i  = ws;
        sd_i  = sd;
        tick(4);
        sck_i = 1'b1;
        if (pop) begin
            tick(2);
            m_ready = 1'b1;
            tick(1);
            m_ready = 1'b0;
            tick(1);
        end else begin
            tick(4);
        end
    endtask

    // n SCK periods with WS=ch: first carries the previous word's LSB, then MSB..bit1.
    task automatic send_word(input logic ch, input logic [31:0] val, input int n, input bit pop_first);
        for (int i = 0; i < n; i++) begin
            if (i == 0) send_bit(ch, pend, pop_first);
            else        send_bit(ch, val[n-i], 1'b0);
        end
        pend = val[0];
    endtask

    task automatic start();
        rst = 1'b1; enable = 1'b0; ws_i = 1'b1; sck_i = 1'b0; sd_i = 1'b0;
        m_ready = 1'b0; ovf_clr = 1'b0; pend = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(4);
        enable = 1'b1;
        tick(2);
        q.delete();
    endtask

    task automatic wait_q(input string tag, input int n);
        for (int i = 0; i < 400 && q.size() < n; i++) tick(1);
        chk(tag, 32'(q.size()), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        w = '{16'hC001, 16'h0BAD, 16'hF00D, 16'h7E57, 16'h1357, 16'h8642};
        rst = 1'b1; enable = 1'b0; ws_i = 1'b0; sck_i = 1'b0; sd_i = 1'b0;
        m_ready = 1'b0; ovf_clr = 1'b0; pend = 1'b0;
        tick(3);
        chk("rst_valid", 32'(m_valid), 32'h0);
        chk("rst_data", 32'(m_data), 32'h0);
        chk("rst_chan", 32'(m_chan), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);

        // Partial word, then L/R pair; first boundary must be discarded
        start();
        send_word(1'b1, 32'hFFFF, 5, 1'b0);
        send_word(1'b0, 32'hA5C3, 16, 1'b0);
        chk("t1_discard_level", 32'(fifo_level), 32'h0);
        m_ready = 1'b1;
        send_word(1'b1, 32'h1234, 16, 1'b0);
        send_word(1'b0, 32'h0, 1, 1'b0);
        wait_q("t1_count", 2);
        tick(8);
        chk("t1_count_final", 32'(q.size()), 32'd2);
        chk("t1_left", 32'(q[0]), 32'h0A5C3);
        chk("t1_right", 32'(q[1]), 32'h11234);

        // 24-bit slot truncated to 16 bits
        start();
        m_ready = 1'b1;
        send_word(1'b0, 32'hABCDEF, 24, 1'b0);
        send_word(1'b1, 32'h0, 1, 1'b0);
        wait_q("t2_count", 1);
        chk("t2_trunc", 32'(q[0]), 32'h0ABCD);

        // 8-bit slot zero-padded
        start();
        m_ready = 1'b1;
        send_word(1'b0, 32'h5A, 8, 1'b0);
        send_word(1'b1, 32'h0, 1, 1'b0);
        wait_q("t3_count", 1);
        chk("t3_pad", 32'(q[0]), 32'h05A00);

        // Overflow: six words into a depth-4 FIFO with the consumer stalled
        start();
        for (int i = 0; i < 6; i++) send_word(1'(i % 2), 32'(w[i]), 16, 1'b0);
        send_word(1'b0, 32'h0, 1, 1'b0);
        tick(4);
        chk("t4_level_full", 32'(fifo_level), 32'd4);
        chk("t4_ovf_set", 32'(overflow), 32'h1);
        chk("t4_head_data", 32'(m_data), 32'(w[0]));
        m_ready = 1'b1;
        wait_q("t4_count", 4);
        tick(8);
        chk("t4_count_final", 32'(q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t4_w%0d", i), 32'(q[i]), 32'({1'(i % 2), w[i]}));
        chk("t4_level_empty", 32'(fifo_level), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'h0);

        // Full FIFO: pop coincides with a boundary push
        start();
        for (int i = 0; i < 5; i++) send_word(1'(i % 2), 32'(w[i]), 16, 1'b0);
        chk("t5_level_pre", 32'(fifo_level), 32'd4);
        send_word(1'b1, 32'h0, 1, 1'b1);
        tick(4);
        chk("t5_level_post", 32'(fifo_level), 32'd4);
        chk("t5_ovf", 32'(overflow), 32'h0);
        m_ready = 1'b1;
        wait_q("t5_count", 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t5_w%0d", i), 32'(q[i]), 32'({1'(i % 2), w[i]}));

        // Reset mid-word with two entries buffered
        start();
        send_word(1'b0, 32'(w[0]), 16, 1'b0);
        send_word(1'b1, 32'(w[1]), 16, 1'b0);
        send_word(1'b0, 32'(w[2]), 6, 1'b0);
        chk("t6_level_pre", 32'(fifo_level), 32'd2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_valid", 32'(m_valid), 32'h0);
        chk("t6_level", 32'(fifo_level), 32'd0);
        m_ready = 1'b1;
        send_word(1'b1, 32'h0F0F, 16, 1'b0);
        send_word(1'b0, 32'h3333, 16, 1'b0);
        tick(8);
        chk("t6_count", 32'(q.size()), 32'd1);
        chk("t6_word", 32'(q[0]), 32'h10F0F);

        // Enable dropped mid-word for 20 clk
        start();
        send_word(1'b0, 32'(w[0]), 16, 1'b0);
        send_word(1'b1, 32'(w[1]), 16, 1'b0);
        send_word(1'b0, 32'(w[2]), 16, 1'b0);
        send_word(1'b1, 32'(w[3]), 6, 1'b0);
        enable = 1'b0;
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        tick(4);
        enable = 1'b1;
        chk("t7_level_dis", 32'(fifo_level), 32'd3);
        send_word(1'b1, 32'hFFFF, 4, 1'b0);
        send_word(1'b0, 32'h4C4C, 16, 1'b0);
        chk("t7_discard", 32'(fifo_level), 32'd3);
        send_word(1'b1, 32'h0, 1, 1'b0);
        tick(4);
        chk("t7_level_full", 32'(fifo_level), 32'd4);
        chk("t7_ovf", 32'(overflow), 32'h0);
        m_ready = 1'b1;
        wait_q("t7_count", 4);
        for (int i = 0; i < 3; i++) chk($sformatf("t7_w%0d", i), 32'(q[i]), 32'({1'(i % 2), w[i]}));
        chk("t7_new", 32'(q[3]), 32'h04C4C);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_rx_slave.md
Name: i2s_rx_slave

Overview:
- I2S slave receiver sitting directly downstream of the chip pad frame; consumes the pad-side inputs sck_i, ws_i and sd_i, which are driven externally by an I2S master.
- Synchronises the three inputs into the system clock domain, detects SCK rising edges and deserialises Philips-format I2S words.
- Buffers each channel-tagged sample in a small FIFO and presents it to the peripheral/APB side through a valid/ready stream.

Parameters:
- DATA_WIDTH, 16, stored sample width in bits; longer slots are truncated, shorter slots are zero-padded.
- FIFO_DEPTH, 4, number of sample entries buffered; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  receiver enable.
- sck_i  in  1  I2S bit clock from pad (asynchronous to clk).
- ws_i  in  1  I2S word select from pad; 0 = left channel, 1 = right channel.
- sd_i  in  1  I2S serial data from pad.
- m_valid  out  1  FIFO head entry is valid.
- m_ready  in  1  consumer accepts the head entry.
- m_data  out  DATA_WIDTH  sample, MSB-aligned.
- m_chan  out  1  channel tag of m_data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full.
- ovf_clr  in  1  one-cycle pulse that clears overflow.

Behaviour:
- Reset (rst=1 at a clk edge):
  - m_valid=0, m_data=0, m_chan=0, fifo_level=0, overflow=0.
  - All synchroniser flops cleared; bit_cnt=0, shreg=0, synced=0.
  - Reset applied mid-word discards the partial word and all FIFO contents.
- Synchronisation:
  - sck_i, ws_i and sd_i each pass through a 2-flop synchroniser.
  - A rising edge is flagged when the synced SCK is 1 and the previous synced SCK was 0.
  - Edge pulse latency is 3 clk cycles after the pin edge.
  - Requirement: SCK high time and low time must each be at least 3 clk cycles (f_clk ≥ 6·f_sck).
  - WS and SD are sampled from their synced values in the same cycle as the edge pulse.
- Deserialisation, on each detected rising edge while enable=1:
  - Let ws_prev be the WS value sampled at the previous rising edge.
  - Boundary: the sampled WS differs from ws_prev.
  - Per-edge bit capture:
    - If bit_cnt < DATA_WIDTH: shreg[DATA_WIDTH-1-bit_cnt] ← sd, and bit_cnt increments.
    - If bit_cnt ≥ DATA_WIDTH: the bit is ignored, which truncates long slots.
  - Per-edge handling on a boundary:
    - The bit sampled at the boundary edge is the LSB slot of the outgoing word (one-bit I2S delay).
    - Capture that bit per the rule above, then form the word {chan=ws_prev, data=shreg including this bit}.
    - If synced=1, push the word to the FIFO. Otherwise discard it and set synced=1.
    - Then clear shreg to 0 and bit_cnt to 0, and set ws_prev ← ws.
  - Unused low bits of the word remain 0 (short slots are zero-padded).
- enable=0:
  - Edges are ignored.
  - shreg, bit_cnt and synced are cleared, and ws_prev ← synced WS each cycle.
  - FIFO contents and the stream interface keep operating.
  - The first boundary after enable rises is always discarded.
- FIFO:
  - Registered, first-word fall-through.
  - m_valid rises the cycle after a push into an empty FIFO.
  - A pop occurs when m_valid && m_ready.
  - Push while full with no pop in the same cycle: the word is dropped and overflow←1. Existing contents are unchanged.
  - Push while full with a simultaneous pop: the push is accepted and the level stays FIFO_DEPTH.
  - Simultaneous push and pop at any level: fifo_level is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - m_data and m_chan are stable while m_valid=1 && m_ready=0.
- overflow: cleared by ovf_clr. If ovf_clr and a new overflow occur in the same cycle, overflow=1 (set wins).

Test Plan:
- SCK=clk/8, 16-bit slots. Send L=0xA5C3 then R=0x1234, preceded by one partial word, with m_ready=1 → first boundary produces no output. Then (m_chan=0, m_data=0xA5C3), then (m_chan=1, m_data=0x1234), each arriving 3–4 clk after its boundary edge.
- 24-bit slots carrying L=0xABCDEF → m_data=0xABCD. 8-bit slots carrying L=0x5A → m_data=0x5A00.
- m_ready=0, send 6 synced words W0..W5 → fifo_level=4, overflow=1. Then m_ready=1 → W0..W3 delivered in order, with none of W4/W5. Pulse ovf_clr → overflow=0.
- FIFO at level 4 with a pop coinciding with a boundary push → level stays 4, the new word is retained, overflow stays 0.
- Assert rst for 1 clk in mid-word while the FIFO holds 2 entries → m_valid=0, fifo_level=0. The next boundary is discarded and the following word is correct.
- Drop enable mid-word for 20 clk, then re-enable → no partial word is output, the first boundary after re-enable is discarded, and existing FIFO entries are still delivered intact.
